instr_fetch: RTL and testbench

- Fetch stage sitting between instruction memory and the instruction pointer.
- Reads the word at the current ip over a req/ack memory handshake, then holds it for the decoder.
- Drives the instruction pointer's adj input: 0 = hold, 1 = sequential step, signed offset = taken branch.
- A memory-timeout counter flags a sticky fetch fault.

---
 rtl/instr_fetch_pkg.sv | 12 +
 rtl/instr_fetch_timeout.sv | 37 +++
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the fetch stage: word width and state encoding.
package instr_fetch_pkg;

    localparam int WORD_WIDTH = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

endpackage

// File: rtl/instr_fetch_timeout.sv
// Memory-wait counter for the fetch stage. Counts up while enabled and
// flags expiry once the count reaches LIMIT-1, so the owner can decide on
// that same edge whether an arriving ack still wins.
module fetch_timeout #(
    parameter int LIMIT     = 15,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 update_clk,
    input  logic                 reset_clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] count;

    // Clear has priority over load, load over counting.
    always_ff @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is a plain compare so it is valid in the cycle the count lands.
    always_comb begin
        expired = (count == CNT_WIDTH'(LIMIT - 1));
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads the word at ip, holds it for the decoder, then steps
// the instruction pointer by 1 or by a branch offset for one cycle.
//
//   state    | meaning
//   ST_IDLE  | one cycle after reset release
//   ST_FETCH | mem_req high, waiting for mem_ack, timeout counting
//   ST_HOLD  | instr_valid high, waiting for decoder or branch
//   ST_STEP  | adj non-zero for this cycle; ip advances at closing edge
//   ST_FAULT | memory timed out; terminal until reset
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_WIDTH   = 4
) (
    input  logic                  update_clk,
    input  logic                  reset_clk,
    input  logic [WORD_WIDTH-1:0] ip,
    output logic [WORD_WIDTH-1:0] adj,
    output logic                  mem_req,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [WORD_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  dec_ready,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_offset,
    output logic                  fault
);

    logic [2:0] state;
    logic       tmo_clr;
    logic       tmo_en;
    logic       tmo_expired;

    // ip only moves in STEP, so the address is stable for the whole FETCH.
    always_comb begin
        mem_addr = ip;
    end

    // Timeout runs only while waiting in FETCH; an ack or leaving FETCH rearms it.
    always_comb begin
        tmo_en  = (state == ST_FETCH);
        tmo_clr = (state != ST_FETCH) || mem_ack;
    end

    fetch_timeout #(
        .LIMIT    (MEM_TIMEOUT),
        .CNT_WIDTH(TMO_WIDTH)
    ) u_timeout (
        .update_clk(update_clk),
        .reset_clk (reset_clk),
        .clr       (tmo_clr),
        .en        (tmo_en),
        .load      (1'b0),
        .load_val  ({TMO_WIDTH{1'b0}}),
        .expired   (tmo_expired)
    );

    // Sequencer; all outputs are registered alongside the state.
    always_ff @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) begin
            state       <= ST_IDLE;
            adj         <= '0;
            mem_req     <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_FETCH;
                    mem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        instr       <= mem_rdata;
                        instr_valid <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= ST_HOLD;
                    end else if (tmo_expired) begin
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= ST_FAULT;
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        adj         <= branch_offset;
                        instr_valid <= 1'b0;
                        state       <= ST_STEP;
                    end else if (dec_ready) begin
                        adj         <= {{(WORD_WIDTH-1){1'b0}}, 1'b1};
                        instr_valid <= 1'b0;
                        state       <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    adj     <= '0;
                    mem_req <= 1'b1;
                    state   <= ST_FETCH;
                end
                ST_FAULT: begin
                    adj         <= '0;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    adj         <= '0;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized transactions
// checked against a per-instruction reference model. The bench owns the
// instruction pointer register that the stage steers through adj.
module tb_instr_fetch;

    logic        update_clk = 1'b0;
    logic        reset_clk  = 1'b1;
    logic [15:0] ip;
    logic [15:0] ip_init = 16'd0;
    logic [15:0] adj;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        dec_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'd0;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    instr_fetch dut (
        .update_clk   (update_clk),
        .reset_clk    (reset_clk),
        .ip           (ip),
        .adj          (adj),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .dec_ready    (dec_ready),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .fault        (fault)
    );

    always #5 update_clk = ~update_clk;

    // Instruction pointer: ip <= ip + adj, wrapping modulo 2**16.
    always @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) ip <= ip_init;
        else           ip <= ip + adj;
    end

    task automatic do_reset(input logic [15:0] init);
        mem_ack = 1'b0; mem_rdata = 16'd0; dec_ready = 1'b0;
        branch_taken = 1'b0; branch_offset = 16'd0;
        ip_init = init;
        reset_clk = 1'b1;
        @(negedge update_clk);
        @(negedge update_clk);
        reset_clk = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(16'h00A5);
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %0b want 0", mem_req); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", instr_valid); end
        vectors++; if (adj !== 16'd0) begin miscompares++; $display("FAIL rst_adj got %h want 0000", adj); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault got %0b want 0", fault); end
        vectors++; if (instr !== 16'd0) begin miscompares++; $display("FAIL rst_instr got %h want 0000", instr); end
        vectors++; if (mem_addr !== 16'h00A5) begin miscompares++; $display("FAIL rst_addr got %h want 00a5", mem_addr); end
    endtask

    task automatic test_sequential;
        do_reset(16'd0);
        @(negedge update_clk);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 16'd0) begin miscompares++; $display("FAIL seq_fetch got req=%0b addr=%h want 1/0000", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        @(negedge update_clk);
        vectors++; if (instr !== 16'h1234 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL seq_hold got instr=%h v=%0b want 1234/1", instr, instr_valid); end
        vectors++; if (mem_req !== 1'b0 || adj !== 16'd0) begin miscompares++; $display("FAIL seq_hold_req got req=%0b adj=%h want 0/0000", mem_req, adj); end
        mem_ack = 1'b0; dec_ready = 1'b1;
        @(negedge update_clk);
        vectors++; if (adj !== 16'd1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL seq_step got adj=%h v=%0b want 0001/0", adj, instr_valid); end
        dec_ready = 1'b0;
        @(negedge update_clk);
        vectors++; if (adj !== 16'd0 || mem_req !== 1'b1 || mem_addr !== 16'd1) begin miscompares++; $display("FAIL seq_next got adj=%h req=%0b addr=%h want 0000/1/0001", adj, mem_req, mem_addr); end
    endtask

    task automatic test_stall;
        do_reset(16'd5);
        @(negedge update_clk);
        mem_ack = 1'b1; mem_rdata = 16'hABCD;
        @(negedge update_clk);
        mem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vectors++; if (instr !== 16'hABCD || instr_valid !== 1'b1 || adj !== 16'd0 || mem_addr !== 16'd5) begin
                miscompares++; $display("FAIL stall_%0d got instr=%h v=%0b adj=%h addr=%h want abcd/1/0000/0005", k, instr, instr_valid, adj, mem_addr);
            end
            @(negedge update_clk);
        end
        vectors++; if (instr_valid !== 1'b1 || adj !== 16'd0) begin miscompares++; $display("FAIL stall_end got v=%0b adj=%h want 1/0000", instr_valid, adj); end
        dec_ready = 1'b1;
        @(negedge update_clk);
        dec_ready = 1'b0;
        vectors++; if (adj !== 16'd1) begin miscompares++; $display("FAIL stall_step got adj=%h want 0001", adj); end
        @(negedge update_clk);
        vectors++; if (mem_addr !== 16'd6 || adj !== 16'd0) begin miscompares++; $display("FAIL stall_next got addr=%h adj=%h want 0006/0000", mem_addr, adj); end
    endtask

    task automatic test_branch;
        logic [15:0] start [2];
        logic [15:0] offs  [2];
        logic [15:0] dest  [2];
        start[0] = 16'd10; offs[0] = 16'hFFFD; dest[0] = 16'd7;
        start[1] = 16'd1;  offs[1] = 16'hFFFE; dest[1] = 16'hFFFF;
        for (int c = 0; c < 2; c++) begin
            do_reset(start[c]);
            @(negedge update_clk);
            mem_ack = 1'b1; mem_rdata = 16'h0F0F;
            @(negedge update_clk);
            mem_ack = 1'b0; branch_taken = 1'b1; dec_ready = 1'b1; branch_offset = offs[c];
            @(negedge update_clk);
            branch_taken = 1'b0; dec_ready = 1'b0;
            vectors++; if (adj !== offs[c]) begin miscompares++; $display("FAIL br%0d_adj got %h want %h", c, adj, offs[c]); end
            @(negedge update_clk);
            vectors++; if (mem_addr !== dest[c] || mem_req !== 1'b1 || adj !== 16'd0) begin
                miscompares++; $display("FAIL br%0d_dest got addr=%h req=%0b adj=%h want %h/1/0000", c, mem_addr, mem_req, adj, dest[c]);
            end
        end
    endtask

    task automatic test_timeout;
        do_reset(16'd3);
        for (int k = 1; k <= 15; k++) begin
            @(negedge update_clk);
            vectors++; if (mem_req !== 1'b1 || fault !== 1'b0) begin miscompares++; $display("FAIL tmo_wait%0d got req=%0b fault=%0b want 1/0", k, mem_req, fault); end
        end
        @(negedge update_clk);
        vectors++; if (fault !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL tmo_fault got fault=%0b req=%0b want 1/0", fault, mem_req); end
        mem_ack = 1'b1; mem_rdata = 16'h4444; dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge update_clk);
            vectors++; if (fault !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || adj !== 16'd0) begin
                miscompares++; $display("FAIL tmo_sticky%0d got fault=%0b req=%0b v=%0b adj=%h want 1/0/0/0000", k, fault, mem_req, instr_valid, adj);
            end
        end
        mem_ack = 1'b0; dec_ready = 1'b0;
    endtask

    task automatic test_ack_last;
        do_reset(16'd40);
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 15; k++) begin
                @(negedge update_clk);
                vectors++; if (mem_req !== 1'b1 || fault !== 1'b0) begin miscompares++; $display("FAIL last%0d_wait%0d got req=%0b fault=%0b want 1/0", r, k, mem_req, fault); end
                if (k == 15) begin mem_ack = 1'b1; mem_rdata = 16'h5A5A; end
            end
            @(negedge update_clk);
            mem_ack = 1'b0;
            vectors++; if (instr_valid !== 1'b1 || instr !== 16'h5A5A || fault !== 1'b0) begin
                miscompares++; $display("FAIL last%0d_hold got v=%0b instr=%h fault=%0b want 1/5a5a/0", r, instr_valid, instr, fault);
            end
            dec_ready = 1'b1;
            @(negedge update_clk);
            dec_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        do_reset(16'd20);
        @(negedge update_clk);
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL mid_fetch got req=%0b want 1", mem_req); end
        reset_clk = 1'b1;
        #1;
        vectors++; if (mem_req !== 1'b0 || fault !== 1'b0) begin miscompares++; $display("FAIL mid_fetch_rst got req=%0b fault=%0b want 0/0", mem_req, fault); end
        @(negedge update_clk);
        reset_clk = 1'b0;
        @(negedge update_clk);
        mem_ack = 1'b1; mem_rdata = 16'd77;
        @(negedge update_clk);
        mem_ack = 1'b0; dec_ready = 1'b1;
        @(negedge update_clk);
        dec_ready = 1'b0;
        vectors++; if (adj !== 16'd1) begin miscompares++; $display("FAIL mid_step got adj=%h want 0001", adj); end
        reset_clk = 1'b1;
        #1;
        vectors++; if (adj !== 16'd0 || instr_valid !== 1'b0 || instr !== 16'd0 || mem_req !== 1'b0) begin
            miscompares++; $display("FAIL mid_step_rst got adj=%h v=%0b instr=%h req=%0b want 0000/0/0000/0", adj, instr_valid, instr, mem_req);
        end
        @(negedge update_clk);
        @(negedge update_clk);
        vectors++; if (mem_addr !== 16'd20) begin miscompares++; $display("FAIL mid_ip got addr=%h want 0014", mem_addr); end
        reset_clk = 1'b0;
    endtask

    // Randomized instructions: each is (ack delay, data, stall length, branch?, offset).
    // Inputs that must be ignored outside their state are driven with noise.
    task automatic test_random;
        logic [15:0] ipm;
        logic [15:0] data;
        logic [15:0] off;
        logic [15:0] adj_e;
        logic        br;
        int          d;
        int          s;
        ipm = 16'($urandom);
        do_reset(ipm);
        mem_ack = 1'($urandom_range(0, 1)); dec_ready = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        for (int t = 0; t < 40; t++) begin
            d    = $urandom_range(0, 14);
            s    = $urandom_range(0, 4);
            data = 16'($urandom);
            br   = 1'($urandom_range(0, 1));
            off  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            for (int c = 0; c <= d; c++) begin
                @(negedge update_clk);
                vectors++; if (mem_req !== 1'b1 || instr_valid !== 1'b0 || adj !== 16'd0 || mem_addr !== ipm || fault !== 1'b0) begin
                    miscompares++; $display("FAIL rnd%0d_fetch%0d got req=%0b v=%0b adj=%h addr=%h fault=%0b want 1/0/0000/%h/0", t, c, mem_req, instr_valid, adj, mem_addr, fault, ipm);
                end
                mem_ack = (c == d); mem_rdata = (c == d) ? data : 16'($urandom);
                dec_ready = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
                branch_offset = 16'($urandom);
            end
            for (int c = 0; c <= s; c++) begin
                @(negedge update_clk);
                vectors++; if (instr_valid !== 1'b1 || instr !== data || mem_req !== 1'b0 || adj !== 16'd0 || mem_addr !== ipm) begin
                    miscompares++; $display("FAIL rnd%0d_hold%0d got v=%0b instr=%h req=%0b adj=%h addr=%h want 1/%h/0/0000/%h", t, c, instr_valid, instr, mem_req, adj, mem_addr, data, ipm);
                end
                mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
                branch_offset = (c == s) ? off : 16'($urandom);
                if (c < s) begin
                    dec_ready = 1'b0; branch_taken = 1'b0;
                end else begin
                    branch_taken = br;
                    dec_ready = br ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
            adj_e = br ? off : 16'd1;
            @(negedge update_clk);
            vectors++; if (adj !== adj_e || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
                miscompares++; $display("FAIL rnd%0d_step got adj=%h v=%0b req=%0b want %h/0/0", t, adj, instr_valid, mem_req, adj_e);
            end
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
            dec_ready = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
            branch_offset = 16'($urandom);
            ipm = ipm + adj_e;
        end
        mem_ack = 1'b0; dec_ready = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_timeout();
        test_ack_last();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
